// File: rtl/fifo_pkg.sv
// Shared helpers and types for the first-word-fall-through FIFO.
package fifo_pkg;

    // Pointer index width (without the wrap bit).
    function automatic int unsigned fifo_addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy counter width; must hold the value DEPTH itself.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Error classification for scoreboard reporting.
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVF,
        ERR_UNF
    } fifo_err_e;

endpackage

// File: rtl/fifo_ptr_ctl.sv
// Pointer, occupancy, flag and sticky-error control for fifo_fwft_ctl.
// Optional watermark output enabled by defining FIFO_WATERMARK_EN.
module fifo_ptr_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    localparam int unsigned AW      = fifo_addr_w(DEPTH),
    localparam int unsigned CW      = fifo_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic          wr_en,
    output logic [AW:0]   waddr,
    output logic [AW:0]   raddr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
`ifdef FIFO_WATERMARK_EN
    ,
    output logic [CW-1:0] max_count
`endif
);

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [AW:0]   waddr_q, waddr_d;
    logic [AW:0]   raddr_q, raddr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_ok, pop_ok;
`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] max_q, max_d;
`endif

    // Next-state: accept/drop decisions, pointer and count update, flags from next count.
    always_comb begin
        // Full with a simultaneous pop frees a slot; empty with push is the bypass path.
        push_ok = push && (!full_q || pop);
        pop_ok  = pop && (!empty_q || push);

        waddr_d = waddr_q;
        raddr_d = raddr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (push && full_q && !pop);
        unf_d   = unf_q | (pop && empty_q && !push);

        if (push_ok) waddr_d = waddr_q + PTR_ONE;
        if (pop_ok)  raddr_d = raddr_q + PTR_ONE;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        af_d    = (32'(count_d) >= AF_LEVEL);
        ae_d    = (32'(count_d) <= AE_LEVEL);

        if (flush) begin
            waddr_d = '0;
            raddr_d = '0;
            count_d = '0;
            empty_d = 1'b1;
            full_d  = 1'b0;
            af_d    = 1'b0;
            ae_d    = 1'b1;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end

`ifdef FIFO_WATERMARK_EN
        max_d = (count_d > max_q) ? count_d : max_q;
        if (flush) max_d = '0;
`endif

        // RAM write only for accepted pushes that are not cancelled by rst/flush.
        wr_en = push_ok && !flush && !rst;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            raddr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef FIFO_WATERMARK_EN
            max_q   <= '0;
`endif
        end else begin
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef FIFO_WATERMARK_EN
            max_q   <= max_d;
`endif
        end
    end

    assign waddr        = waddr_q;
    assign raddr        = raddr_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
`ifdef FIFO_WATERMARK_EN
    assign max_count    = max_q;
`endif

endmodule

// File: rtl/fifo_fwft_ctl.sv
// Single-clock first-word-fall-through FIFO: storage array and head mux.
// Optional high-water mark output max_count enabled by defining FIFO_WATERMARK_EN.
module fifo_fwft_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WIDTH    = 36,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    localparam int unsigned AW      = fifo_addr_w(DEPTH),
    localparam int unsigned CW      = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_WATERMARK_EN
    ,
    output logic [CW-1:0]    max_count
`endif
);

    logic             wr_en;
    logic [AW:0]      waddr;
    logic [AW:0]      raddr;
    logic [WIDTH-1:0] mem [DEPTH];

    fifo_ptr_ctl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ptr_ctl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .wr_en        (wr_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_WATERMARK_EN
        ,
        .max_count    (max_count)
`endif
    );

    // Storage array; contents are deliberately not cleared by rst or flush.
    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr[AW-1:0]] <= din;
    end

    // Head data: fall through from din while empty so a same-cycle pop sees it.
    always_comb begin
        dout = empty ? din : mem[raddr[AW-1:0]];
    end

endmodule

// File: tb/tb_fifo_fwft_ctl.sv
// Directed, table-driven bench for fifo_fwft_ctl (DEPTH=8, WIDTH=8, AF=6, AE=1).
module tb_fifo_fwft_ctl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic             clk = 1'b0;
    logic             rst, flush, push, pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]       count;
`ifdef FIFO_WATERMARK_EN
    logic [3:0]       max_count;
`endif

    int n_total  = 0;
    int n_passed = 0;

    typedef struct {
        logic       rst, flush, push, pop;
        logic [7:0] din;
        logic       chk_dout;
        logic [7:0] dout;
        logic [3:0] count;
        logic       ovf, unf;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    fifo_fwft_ctl #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .din          (din),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_WATERMARK_EN
        ,
        .max_count    (max_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_passed++;
    endtask

    // Flags follow directly from the expected occupancy and the thresholds.
    task automatic check_state(input string tag, input logic [3:0] cnt, input logic ovf,
                               input logic unf);
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, " full"}, 32'(full), 32'(cnt == 4'(DEPTH)));
        check({tag, " almost_full"}, 32'(almost_full), 32'(32'(cnt) >= AF));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(32'(cnt) <= AE));
        check({tag, " overflow"}, 32'(overflow), 32'(ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(unf));
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic pu, input logic po,
                                input logic [7:0] d, input logic cd, input logic [7:0] ed,
                                input logic [3:0] cnt, input logic ovf, input logic unf,
                                input string tag);
        vec_t v;
        v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.din = d;
        v.chk_dout = cd; v.dout = ed; v.count = cnt; v.ovf = ovf; v.unf = unf; v.tag = tag;
        return v;
    endfunction

    // Drive on the falling edge, check head data before the rising edge, state after it.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; flush = v.flush; push = v.push; pop = v.pop; din = v.din;
        #1;
        if (v.chk_dout) check({v.tag, " dout"}, 32'(dout), 32'(v.dout));
        @(posedge clk);
        #1;
        check_state(v.tag, v.count, v.ovf, v.unf);
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 4'd0, 1'b0, 1'b0);

        // Fill to full, overflow, drain, underflow, bypass, flush.
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 0, 1, 0, 8'(i), 1, 8'h01, 4'(i), 0, 0, $sformatf("fill%0d", i)));
        tbl.push_back(mk(0, 0, 1, 0, 8'h99, 1, 8'h01, 4'd8, 1, 0, "ovf"));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 0, 1, 8'h00, 1, 8'(k), 4'(8 - k), 1, 0,
                             $sformatf("drain%0d", k)));
        tbl.push_back(mk(0, 0, 0, 1, 8'h33, 1, 8'h33, 4'd0, 1, 1, "unf"));
        tbl.push_back(mk(0, 0, 1, 0, 8'h11, 1, 8'h11, 4'd1, 1, 1, "push11"));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 1, 8'h11, 4'd0, 1, 1, "pop11"));
        tbl.push_back(mk(0, 0, 1, 1, 8'hA5, 1, 8'hA5, 4'd0, 1, 1, "bypass"));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 0, "flush0"));
        foreach (tbl[i]) apply(tbl[i]);

        // Wrap: hold three entries while pointers roll past 2*DEPTH.
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 1, 0, 8'(8'h10 + i), 0, 8'h00, 4'(i + 1), 0, 0,
                     $sformatf("wload%0d", i)));
        for (int i = 0; i < 20; i++)
            apply(mk(0, 0, 1, 1, 8'(8'h13 + i), 1, 8'(8'h10 + i), 4'd3, 0, 0,
                     $sformatf("wrap%0d", i)));
`ifdef FIFO_WATERMARK_EN
        check("max_count", 32'(max_count), 32'd3);
`endif

        // Flush with a same-cycle push: contents and errors gone, push not stored.
        apply(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 0, "fl_clr"));
        apply(mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 1, "fl_unf"));
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 1, 0, 8'(8'h40 + i), 0, 8'h00, 4'(i + 1), 0, 1,
                     $sformatf("fl_load%0d", i)));
        apply(mk(0, 1, 1, 0, 8'hEE, 0, 8'h00, 4'd0, 0, 0, "flush"));
        apply(mk(0, 0, 0, 0, 8'h77, 1, 8'h77, 4'd0, 0, 0, "fl_after"));

        // Same again with reset.
        apply(mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 4'd0, 0, 1, "rs_unf"));
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 1, 0, 8'(8'h50 + i), 0, 8'h00, 4'(i + 1), 0, 1,
                     $sformatf("rs_load%0d", i)));
        apply(mk(1, 0, 1, 0, 8'hEE, 0, 8'h00, 4'd0, 0, 0, "reset2"));
        apply(mk(0, 0, 0, 0, 8'h78, 1, 8'h78, 4'd0, 0, 0, "rs_after"));
`ifdef FIFO_WATERMARK_EN
        check("max_count_rst", 32'(max_count), 32'd0);
`endif

        idle();
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
